// File: rtl/insn_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//  INSN_W   : instruction word width
//  PC_STEP  : byte increment between consecutive instruction words
//  NOP      : NOP encoding shared with the decoder. It is also the reset value of the
//             prefetch storage, so insn reads as 0 out of reset.
//  fetch_state_e : fetch FSM states
//  align_pc : forces an address onto a word boundary (bit0 cleared)
package insn_fetch_pkg;

    localparam int          INSN_W  = 16;
    localparam logic [15:0] PC_STEP = 16'd2;
    localparam logic [15:0] NOP     = 16'h0000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } fetch_state_e;

    function automatic logic [15:0] align_pc(input logic [15:0] pc);
        return pc & ~16'h0001;
    endfunction

endpackage

// File: rtl/insn_fetch_fifo.sv
// Prefetch FIFO for the fetch unit.
// Synchronous FIFO with a registered head. Flush has priority over push and pop.
// Ports:
//  clk, rst          clock, asynchronous active-high reset
//  push, push_data   write one entry (ignored when full, unless a pop frees a slot)
//  pop               drop the head entry (ignored when empty)
//  flush             empty the FIFO
//  count             number of valid entries (0..DEPTH)
//  head              oldest entry
module fetch_fifo
    import insn_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head
);

    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);
    localparam logic [W-1:0]   INIT = W'(NOP);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [W-1:0]  mem_reg [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !flush && (count_reg != '0);
    assign do_push = push && !flush && ((count_reg != FULL) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is reset so the head (and thus insn/insn_pc) reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= INIT;
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch unit: fetches 16-bit words from imem at fetch_pc, buffers them in a
// prefetch FIFO and presents them to the decoder with a valid/ready handshake.
// Execute-stage IP loads arrive on redirect; they flush the FIFO and restart fetching.
// Ports:
//  clk, rst                clock, asynchronous active-high reset
//  imem_req/imem_addr      read request, held with a stable address until imem_ack
//  imem_ack/imem_rdata     request completion and returned word
//  insn/insn_pc/insn_valid head-of-FIFO instruction and its byte address
//  insn_ready              consumer accepts insn this cycle
//  redirect/redirect_pc    new instruction pointer from execute
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [15:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [INSN_W-1:0] insn,
    output logic [15:0]       insn_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    input  logic              redirect,
    input  logic [15:0]       redirect_pc
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e  state_reg, state_next;
    logic [15:0]   fetch_pc_reg, fetch_pc_next;
    logic [15:0]   req_addr_reg, req_addr_next;
    logic          drop_reg, drop_next;
    logic          push;
    logic          pop;
    logic          ack_taken;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({imem_rdata, req_addr_reg}),
        .pop       (pop),
        .flush     (redirect),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign insn_valid = (fifo_count != '0);
    assign insn       = fifo_head[31:16];
    assign insn_pc    = fifo_head[15:0];
    assign pop        = insn_valid && insn_ready;
    assign imem_req   = (state_reg == S_REQ);
    // The request address has its own register: a redirect moves fetch_pc while the
    // outstanding request must keep presenting the old address.
    assign imem_addr  = req_addr_reg;
    // An ack only counts while a request is outstanding.
    assign ack_taken  = (state_reg == S_REQ) && imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= RESET_PC;
            drop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_addr_reg <= req_addr_next;
            drop_reg     <= drop_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_addr_next = req_addr_reg;
        drop_next     = drop_reg;
        push          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (redirect) begin
                    state_next    = S_REQ;
                    req_addr_next = align_pc(redirect_pc);
                end else if ((fifo_count < FULL) || pop) begin
                    // A pop this cycle frees a slot, so a full FIFO resumes at once.
                    state_next    = S_REQ;
                    req_addr_next = fetch_pc_reg;
                end
            end
            S_REQ: begin
                if (ack_taken) begin
                    if (redirect) begin
                        // Word belongs to the old stream; refetch from the new IP.
                        state_next    = S_REQ;
                        req_addr_next = align_pc(redirect_pc);
                        drop_next     = 1'b0;
                    end else if (drop_reg) begin
                        // Discard the stale word; fetch_pc already holds the redirect target.
                        state_next    = S_REQ;
                        req_addr_next = fetch_pc_reg;
                        drop_next     = 1'b0;
                    end else begin
                        push          = 1'b1;
                        fetch_pc_next = fetch_pc_reg + PC_STEP;
                        state_next    = S_IDLE;
                    end
                end else if (redirect) begin
                    // Request cannot be aborted: let it complete and throw the word away.
                    drop_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (redirect) fetch_pc_next = align_pc(redirect_pc);
    end

endmodule
